mips_debug_snapshot: RTL and testbench

Parametrised debug snapshot-and-stream unit for the MIPS pipeline. It latches up to NB_CHAN pipeline segment/control register buses in one clock edge, triggered by a host request or by the processor's end-of-program signal. It then streams the selected channels as a framed, checksummed byte sequence over a valid/ready byte interface to the debug UART. It is the successor to the fixed-width segment-register debug taps: channel count, slot width and channel selection are run-time or compile-time configurable, and streaming tolerates backpressure.

---
 rtl/mips_dbg_pkg.sv | 24 ++
 rtl/dbg_chan_finder.sv | 27 ++
 rtl/mips_debug_snapshot.sv | 188 ++++++++++++++++++
 tb/tb_mips_debug_snapshot.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared types and helpers for the MIPS debug snapshot unit.
// Holds the frame FSM states and width helpers.
package mips_dbg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      CNT,
      CID,
      DAT,
      CHK
   } state_t;

   localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

   function automatic int byteCntW(input int nbSlot);
      return (nbSlot / 8 > 1) ? $clog2(nbSlot / 8) : 1;
   endfunction

   function automatic int chanIdxW(input int nbChan);
      return (nbChan > 1) ? $clog2(nbChan) : 1;
   endfunction

endpackage

// File: rtl/dbg_chan_finder.sv
// Priority encoder: next enabled channel above the current one.
// fromStart returns the lowest enabled channel instead.
module dbg_chan_finder
   import mips_dbg_pkg::*;
#(
   parameter int NB_CHAN = 6,
   localparam int IW = chanIdxW(NB_CHAN)
) (
   input  logic [NB_CHAN-1:0] mask,
   input  logic [IW-1:0]      cur,
   input  logic               fromStart,
   output logic [IW-1:0]      nextIdx,
   output logic               noneLeft
);

   always_comb begin
      nextIdx  = '0;
      noneLeft = 1'b1;
      for (int k = NB_CHAN - 1; k >= 0; k--) begin
         if (mask[k] && (fromStart || k > int'(cur))) begin
            nextIdx  = IW'(k);
            noneLeft = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mips_debug_snapshot.sv
// Debug snapshot-and-stream unit: latches channel buses on a
// trigger and streams them as a checksummed byte frame.
module mips_debug_snapshot
   import mips_dbg_pkg::*;
#(
   parameter int         NB_CHAN  = 6,
   parameter int         NB_SLOT  = 144,
   parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
   input  logic                       clk,
   input  logic                       i_reset,
   input  logic [NB_CHAN*NB_SLOT-1:0] i_chan_data,
   input  logic [NB_CHAN-1:0]         i_chan_mask,
   input  logic                       i_capture,
   input  logic                       i_end,
   input  logic                       i_auto_en,
   input  logic                       i_clr_overrun,
   output logic [7:0]                 o_tx_data,
   output logic                       o_tx_valid,
   input  logic                       i_tx_ready,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_overrun
);

   localparam int NBYTE = NB_SLOT / 8;
   localparam int BW    = byteCntW(NB_SLOT);
   localparam int IW    = chanIdxW(NB_CHAN);
   localparam int CW    = $clog2(NB_CHAN + 1);
   localparam int SW    = NB_CHAN * NB_SLOT;

   state_t         state, stateN;
   logic [SW-1:0]  snap;
   logic [NB_CHAN-1:0] maskQ;
   logic [CW-1:0]  cnt, popMask;
   logic [7:0]     chk, chkN;
   logic [IW-1:0]  chanIdx, chanIdxN;
   logic [BW-1:0]  byteIdx, byteIdxN;
   logic [7:0]     txData, txDataN;
   logic           txValid, txValidN;
   logic           done, doneN;
   logic           overrun, overrunN;
   logic           endQ;
   logic           trig, accept, snapLoad;
   logic [IW-1:0]  nextIdx;
   logic           noneLeft;
   logic [7:0]     chkAcc;

   function automatic logic [7:0] slotByte(
      input logic [SW-1:0] s,
      input logic [IW-1:0] ch,
      input logic [BW-1:0] b
   );
      logic [SW-1:0] sh;
      sh = s >> (int'(ch) * NB_SLOT + (NBYTE - 1 - int'(b)) * 8);
      return sh[7:0];
   endfunction

   dbg_chan_finder #(
      .NB_CHAN (NB_CHAN)
   ) uFinder (
      .mask      (maskQ),
      .cur       (chanIdx),
      .fromStart (state == CNT),
      .nextIdx   (nextIdx),
      .noneLeft  (noneLeft)
   );

   assign trig   = i_capture | (i_auto_en & i_end & ~endQ);
   assign accept = txValid & i_tx_ready;
   assign chkAcc = chk ^ txData;

   always_comb begin
      popMask = '0;
      for (int k = 0; k < NB_CHAN; k++)
         popMask = popMask + CW'(i_chan_mask[k]);
   end

   always_comb begin
      stateN   = state;
      chkN     = chk;
      chanIdxN = chanIdx;
      byteIdxN = byteIdx;
      txDataN  = txData;
      txValidN = txValid;
      doneN    = 1'b0;
      snapLoad = 1'b0;
      overrunN = overrun;
      // a new trigger outranks a simultaneous clear
      if (i_clr_overrun)
         overrunN = 1'b0;
      if (trig && state != IDLE)
         overrunN = 1'b1;
      unique case (state)
         IDLE: if (trig) begin
            snapLoad = 1'b1;
            stateN   = HDR;
            chkN     = '0;
            chanIdxN = '0;
            byteIdxN = '0;
            txDataN  = HDR_BYTE;
            txValidN = 1'b1;
         end
         HDR: if (accept) begin
            stateN  = CNT;
            txDataN = 8'(cnt);
         end
         CNT: if (accept) begin
            chkN = chkAcc;
            if (|maskQ) begin
               stateN   = CID;
               chanIdxN = nextIdx;
               txDataN  = 8'(nextIdx);
            end else begin
               stateN  = CHK;
               txDataN = chkAcc;
            end
         end
         CID: if (accept) begin
            chkN     = chkAcc;
            stateN   = DAT;
            byteIdxN = '0;
            txDataN  = slotByte(snap, chanIdx, '0);
         end
         DAT: if (accept) begin
            chkN = chkAcc;
            if (byteIdx == BW'(NBYTE - 1)) begin
               if (!noneLeft) begin
                  stateN   = CID;
                  chanIdxN = nextIdx;
                  txDataN  = 8'(nextIdx);
               end else begin
                  stateN  = CHK;
                  txDataN = chkAcc;
               end
            end else begin
               byteIdxN = byteIdx + 1'b1;
               txDataN  = slotByte(snap, chanIdx, byteIdx + 1'b1);
            end
         end
         CHK: if (accept) begin
            stateN   = IDLE;
            txValidN = 1'b0;
            doneN    = 1'b1;
         end
         default: stateN = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state   <= IDLE;
         snap    <= '0;
         maskQ   <= '0;
         cnt     <= '0;
         chk     <= '0;
         chanIdx <= '0;
         byteIdx <= '0;
         txData  <= '0;
         txValid <= 1'b0;
         done    <= 1'b0;
         overrun <= 1'b0;
         endQ    <= 1'b0;
      end else begin
         state   <= stateN;
         chk     <= chkN;
         chanIdx <= chanIdxN;
         byteIdx <= byteIdxN;
         txData  <= txDataN;
         txValid <= txValidN;
         done    <= doneN;
         overrun <= overrunN;
         endQ    <= i_end;
         if (snapLoad) begin
            snap  <= i_chan_data;
            maskQ <= i_chan_mask;
            cnt   <= popMask;
         end
      end
   end

   assign o_tx_data  = txData;
   assign o_tx_valid = txValid;
   assign o_busy     = (state != IDLE);
   assign o_done     = done;
   assign o_overrun  = overrun;

endmodule

// File: tb/tb_mips_debug_snapshot.sv
// Directed bench for mips_debug_snapshot with a byte scoreboard.
// Expected frames are queued at stimulus time and popped on accept.
module tb_mips_debug_snapshot;

   localparam int NC = 3;
   localparam int NS = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [NC*NS-1:0] data;
   logic [NC-1:0]  mask;
   logic           cap, endS, autoEn, clrOv;
   logic [7:0]     txData;
   logic           txValid, txReady;
   logic           busy, done, overrun;

   int checks = 0;
   int errors = 0;
   logic [7:0] expQ[$];

   always #5 clk = ~clk;

   mips_debug_snapshot #(
      .NB_CHAN (NC),
      .NB_SLOT (NS)
   ) dut (
      .clk           (clk),
      .i_reset       (rst),
      .i_chan_data   (data),
      .i_chan_mask   (mask),
      .i_capture     (cap),
      .i_end         (endS),
      .i_auto_en     (autoEn),
      .i_clr_overrun (clrOv),
      .o_tx_data     (txData),
      .o_tx_valid    (txValid),
      .i_tx_ready    (txReady),
      .o_busy        (busy),
      .o_done        (done),
      .o_overrun     (overrun)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pushFrame(input logic [NC*NS-1:0] d,
                            input logic [NC-1:0] m);
      logic [7:0] c;
      logic [7:0] b;
      int p;
      p = 0;
      for (int k = 0; k < NC; k++) p += int'(m[k]);
      expQ.push_back(8'hA5);
      expQ.push_back(8'(p));
      c = 8'(p);
      for (int k = 0; k < NC; k++) begin
         if (m[k]) begin
            expQ.push_back(8'(k));
            c ^= 8'(k);
            for (int j = NS / 8 - 1; j >= 0; j--) begin
               b = d[k*NS + j*8 +: 8];
               expQ.push_back(b);
               c ^= b;
            end
         end
      end
      expQ.push_back(c);
   endtask

   task automatic pulseCap();
      cap = 1'b1;
      step();
      cap = 1'b0;
   endtask

   task automatic collect(input bit randRdy,
                          input int capAt,
                          input int clrAt,
                          output int firstCyc,
                          output int doneCyc,
                          output int busyCyc);
      bit stall;
      bit gotDone;
      logic [7:0] held;
      logic [7:0] e;
      stall = 1'b0;
      gotDone = 1'b0;
      held = '0;
      firstCyc = -1;
      doneCyc = -1;
      busyCyc = 0;
      for (int cyc = 1; cyc <= 200 && !gotDone; cyc++) begin
         txReady = randRdy ? 1'($urandom_range(0, 1)) : 1'b1;
         cap = (cyc == capAt);
         clrOv = (cyc == clrAt);
         if (cyc == capAt) data = ~data;
         @(negedge clk);
         if (busy) busyCyc++;
         if (stall) begin
            check("hold_valid", 32'(txValid), 32'd1);
            check("hold_data", 32'(txData), 32'(held));
         end
         if (txValid && txReady) begin
            if (firstCyc < 0) firstCyc = cyc;
            check("byte_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
               e = expQ.pop_front();
               check("tx_byte", 32'(txData), 32'(e));
            end
         end
         if (done) begin
            doneCyc = cyc;
            gotDone = 1'b1;
         end
         stall = txValid & ~txReady;
         held = txData;
         step();
      end
      cap = 1'b0;
      clrOv = 1'b0;
      txReady = 1'b1;
      check("frame_done", 32'(gotDone), 32'd1);
      check("queue_empty", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      int f, d, b;
      bit sawBusy;
      logic [NC*NS-1:0] keep;
      rst = 1'b1;
      cap = 1'b0;
      endS = 1'b0;
      autoEn = 1'b0;
      clrOv = 1'b0;
      txReady = 1'b1;
      data = {16'h00FF, 16'hABCD, 16'h1234};
      mask = 3'b101;
      #1;
      check("rst_data", 32'(txData), 32'd0);
      check("rst_valid", 32'(txValid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      step();
      rst = 1'b0;
      step();

      // basic frame, no backpressure
      expQ = '{8'hA5, 8'h02, 8'h00, 8'h12, 8'h34,
               8'h02, 8'h00, 8'hFF, 8'hD9};
      pulseCap();
      collect(1'b0, 0, 0, f, d, b);
      check("first_cycle", 32'(f), 32'd1);
      check("done_cycle", 32'(d), 32'd10);
      check("busy_len", 32'(b), 32'd9);
      step();

      // empty mask
      mask = 3'b000;
      expQ = '{8'hA5, 8'h00, 8'h00};
      pulseCap();
      collect(1'b0, 0, 0, f, d, b);
      check("empty_busy", 32'(b), 32'd3);
      check("empty_done", 32'(d), 32'd4);
      step();

      // backpressure
      mask = 3'b101;
      pushFrame(data, mask);
      pulseCap();
      collect(1'b1, 0, 0, f, d, b);
      step();

      // overrun mid-frame, snapshot unaffected
      check("ovr_init", 32'(overrun), 32'd0);
      keep = data;
      pushFrame(data, mask);
      pulseCap();
      collect(1'b0, 3, 0, f, d, b);
      data = keep;
      check("ovr_set", 32'(overrun), 32'd1);
      clrOv = 1'b1;
      step();
      clrOv = 1'b0;
      check("ovr_clr", 32'(overrun), 32'd0);

      // trigger + clear on the CHK accept edge
      pushFrame(data, mask);
      pulseCap();
      collect(1'b0, 9, 9, f, d, b);
      data = keep;
      check("ovr_setwins", 32'(overrun), 32'd1);
      check("no_queue_busy", 32'(busy), 32'd0);
      step();
      check("no_queue_busy2", 32'(busy), 32'd0);
      check("no_queue_valid", 32'(txValid), 32'd0);
      clrOv = 1'b1;
      step();
      clrOv = 1'b0;
      check("ovr_clr2", 32'(overrun), 32'd0);

      // auto capture on i_end rising edge
      autoEn = 1'b1;
      mask = 3'b010;
      pushFrame(data, mask);
      endS = 1'b1;
      step();
      collect(1'b0, 0, 0, f, d, b);
      check("auto_first", 32'(f), 32'd1);
      sawBusy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (busy || txValid) sawBusy = 1'b1;
      end
      check("auto_held", 32'(sawBusy), 32'd0);
      autoEn = 1'b0;
      endS = 1'b0;
      step();
      endS = 1'b1;
      sawBusy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (busy || txValid) sawBusy = 1'b1;
      end
      check("auto_off", 32'(sawBusy), 32'd0);
      endS = 1'b0;

      // reset during a data byte
      mask = 3'b101;
      pulseCap();
      step();
      step();
      step();
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_byte", 32'(txData), 32'h12);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(txValid), 32'd0);
      check("mid_rst_data", 32'(txData), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      step();
      rst = 1'b0;
      step();
      pushFrame(data, mask);
      pulseCap();
      collect(1'b0, 0, 0, f, d, b);
      check("post_rst_first", 32'(f), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
